scalar_wb_queue: RTL and testbench

SCALAR_WB_QUEUE -- requirements
Module: scalar_wb_queue

---
 rtl/scalar_wb_queue.sv | 112 +++++++++++
 tb/tb_scalar_wb_queue.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_wb_queue.sv
// Scalar writeback queue: buffers ALU/LSU register writes in FIFO order and
// drains them into the scalar register file, with pending-write hazard lookup.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module scalar_wb_queue #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    alu_wb_valid,
  input  logic [4:0]              alu_wb_rd,
  input  logic [DATA_WIDTH-1:0]   alu_wb_data,
  output logic                    alu_wb_ready,
  input  logic                    lsu_wb_valid,
  input  logic [4:0]              lsu_wb_rd,
  input  logic [DATA_WIDTH-1:0]   lsu_wb_data,
  output logic                    lsu_wb_ready,
  input  logic                    drain_enable,
  output logic                    rf_write_enable,
  output logic [4:0]              rf_rd_address,
  output logic [DATA_WIDTH-1:0]   rf_write_data,
  input  logic [4:0]              query_rs1_address,
  input  logic [4:0]              query_rs2_address,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [4:0]            r_rd   [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];

  logic                  w_accept;
  logic                  w_store;
  logic                  w_pop;
  logic [4:0]            w_sel_rd;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [DEPTH-1:0]      w_occupied;

  assign count = r_count;
  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);

  // Readies are held low while reset is asserted; LSU always outranks ALU.
  assign lsu_wb_ready = reset && !full && !flush;
  assign alu_wb_ready = reset && !full && !flush && !lsu_wb_valid;

  assign w_accept   = (lsu_wb_valid && lsu_wb_ready) || (alu_wb_valid && alu_wb_ready);
  assign w_sel_rd   = lsu_wb_valid ? lsu_wb_rd   : alu_wb_rd;
  assign w_sel_data = lsu_wb_valid ? lsu_wb_data : alu_wb_data;
  assign w_store    = w_accept && (w_sel_rd != 5'd0);

  assign rf_write_enable = reset && drain_enable && !empty && !flush;
  assign rf_rd_address   = empty ? 5'd0 : r_rd[r_head];
  assign rf_write_data   = empty ? '0   : r_data[r_head];
  assign w_pop           = rf_write_enable;

  // An entry is live when its distance from head is below the occupancy.
  always_comb begin
    w_occupied = '0;
    rs1_busy   = 1'b0;
    rs2_busy   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occupied[i] = ({1'b0, PTR_W'(PTR_W'(i) - r_head)} < r_count);
      if (w_occupied[i] && (query_rs1_address != 5'd0) && (r_rd[i] == query_rs1_address))
        rs1_busy = 1'b1;
      if (w_occupied[i] && (query_rs2_address != 5'd0) && (r_rd[i] == query_rs2_address))
        rs2_busy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_store) begin
        r_rd[r_tail]   <= w_sel_rd;
        r_data[r_tail] <= w_sel_data;
        r_tail         <= r_tail + PTR_W'(1);
      end
      if (w_pop)
        r_head <= r_head + PTR_W'(1);
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_scalar_wb_queue.sv
// Directed bench for scalar_wb_queue; accepted writes go into a scoreboard
// queue and are popped and compared whenever the DUT writes the register file.
module tb_scalar_wb_queue;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wbEntry_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        aluWbValid;
  logic [4:0]  aluWbRd;
  logic [31:0] aluWbData;
  logic        aluWbReady;
  logic        lsuWbValid;
  logic [4:0]  lsuWbRd;
  logic [31:0] lsuWbData;
  logic        lsuWbReady;
  logic        drainEnable;
  logic        rfWriteEnable;
  logic [4:0]  rfRdAddress;
  logic [31:0] rfWriteData;
  logic [4:0]  queryRs1;
  logic [4:0]  queryRs2;
  logic        rs1Busy;
  logic        rs2Busy;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  wbEntry_t sbQueue[$];
  int vectorCount = 0;
  int errorCount  = 0;

  scalar_wb_queue #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .alu_wb_valid      (aluWbValid),
    .alu_wb_rd         (aluWbRd),
    .alu_wb_data       (aluWbData),
    .alu_wb_ready      (aluWbReady),
    .lsu_wb_valid      (lsuWbValid),
    .lsu_wb_rd         (lsuWbRd),
    .lsu_wb_data       (lsuWbData),
    .lsu_wb_ready      (lsuWbReady),
    .drain_enable      (drainEnable),
    .rf_write_enable   (rfWriteEnable),
    .rf_rd_address     (rfRdAddress),
    .rf_write_data     (rfWriteData),
    .query_rs1_address (queryRs1),
    .query_rs2_address (queryRs2),
    .rs1_busy          (rs1Busy),
    .rs2_busy          (rs2Busy),
    .count             (count),
    .full              (full),
    .empty             (empty)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic aV, input logic [4:0] aRd, input logic [31:0] aD,
                               input logic lV, input logic [4:0] lRd, input logic [31:0] lD,
                               input logic drn, input logic fl);
    aluWbValid  = aV;
    aluWbRd     = aRd;
    aluWbData   = aD;
    lsuWbValid  = lV;
    lsuWbRd     = lRd;
    lsuWbData   = lD;
    drainEnable = drn;
    flush       = fl;
    #1;
  endtask

  task automatic idle(input logic drn);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, drn, 1'b0);
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic expectPush(input logic [4:0] rd, input logic [31:0] data);
    wbEntry_t e;
    e.rd   = rd;
    e.data = data;
    sbQueue.push_back(e);
  endtask

  task automatic drainCheck(input string tag);
    wbEntry_t e;
    checkOutput({tag, "_we"}, {31'b0, rfWriteEnable}, 32'd1);
    vectorCount++;
    assert (sbQueue.size() != 0)
    else begin
      errorCount++;
      $error("[TB] FAIL %s_sb observed=write expected=no_pending_entry", tag);
    end
    if (sbQueue.size() != 0) begin
      e = sbQueue.pop_front();
      checkOutput({tag, "_rd"},   {27'b0, rfRdAddress}, {27'b0, e.rd});
      checkOutput({tag, "_data"}, rfWriteData, e.data);
    end
  endtask

  initial begin
    reset    = 1'b0;
    queryRs1 = 5'd0;
    queryRs2 = 5'd0;
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    checkOutput("rst_count", {29'b0, count}, 32'd0);
    checkOutput("rst_empty", {31'b0, empty}, 32'd1);
    checkOutput("rst_full",  {31'b0, full}, 32'd0);
    checkOutput("rst_aluRdy", {31'b0, aluWbReady}, 32'd0);
    checkOutput("rst_lsuRdy", {31'b0, lsuWbReady}, 32'd0);
    checkOutput("rst_we", {31'b0, rfWriteEnable}, 32'd0);
    stepClk();
    stepClk();
    idle(1'b0);
    reset = 1'b1;
    stepClk();
    checkOutput("idle_empty", {31'b0, empty}, 32'd1);

    $display("[TB] single ALU push and drain");
    queryRs1 = 5'd5;
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("t1_aluRdy", {31'b0, aluWbReady}, 32'd1);
    checkOutput("t1_busySameCycle", {31'b0, rs1Busy}, 32'd0);
    expectPush(5'd5, 32'hDEAD_BEEF);
    stepClk();
    idle(1'b0);
    checkOutput("t1_count", {29'b0, count}, 32'd1);
    checkOutput("t1_busy", {31'b0, rs1Busy}, 32'd1);
    checkOutput("t1_busyRs2Zero", {31'b0, rs2Busy}, 32'd0);
    checkOutput("t1_weHeld", {31'b0, rfWriteEnable}, 32'd0);
    idle(1'b1);
    drainCheck("t1_drain");
    stepClk();
    idle(1'b0);
    checkOutput("t1_emptyAfter", {31'b0, empty}, 32'd1);
    checkOutput("t1_busyAfter", {31'b0, rs1Busy}, 32'd0);

    $display("[TB] LSU priority over ALU");
    applyStimulus(1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h4444, 1'b0, 1'b0);
    checkOutput("t2_aluRdy", {31'b0, aluWbReady}, 32'd0);
    checkOutput("t2_lsuRdy", {31'b0, lsuWbReady}, 32'd1);
    expectPush(5'd4, 32'h4444);
    stepClk();
    applyStimulus(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    checkOutput("t2_aluRdyNext", {31'b0, aluWbReady}, 32'd1);
    expectPush(5'd3, 32'h3333);
    stepClk();
    idle(1'b0);
    checkOutput("t2_count", {29'b0, count}, 32'd2);
    idle(1'b1);
    drainCheck("t2_drainA");
    stepClk();
    drainCheck("t2_drainB");
    stepClk();
    idle(1'b0);
    checkOutput("t2_empty", {31'b0, empty}, 32'd1);

    $display("[TB] fill to full, push refused during pop");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'(8 + i), 32'hA0 + 32'(i), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      expectPush(5'(8 + i), 32'hA0 + 32'(i));
      stepClk();
    end
    idle(1'b0);
    checkOutput("t3_full", {31'b0, full}, 32'd1);
    checkOutput("t3_count", {29'b0, count}, 32'd4);
    checkOutput("t3_lsuRdy", {31'b0, lsuWbReady}, 32'd0);
    applyStimulus(1'b1, 5'd12, 32'hC0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    checkOutput("t3_aluRdy", {31'b0, aluWbReady}, 32'd0);
    drainCheck("t3_drainFull");
    stepClk();
    idle(1'b0);
    checkOutput("t3_countAfter", {29'b0, count}, 32'd3);
    checkOutput("t3_notFull", {31'b0, full}, 32'd0);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      drainCheck("t3_drainRest");
      stepClk();
    end
    idle(1'b0);
    checkOutput("t3_empty", {31'b0, empty}, 32'd1);

    $display("[TB] same rd ordering and hazard lifetime");
    queryRs1 = 5'd7;
    applyStimulus(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    expectPush(5'd7, 32'h1);
    stepClk();
    applyStimulus(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    expectPush(5'd7, 32'h2);
    stepClk();
    idle(1'b1);
    checkOutput("t4_busyTwo", {31'b0, rs1Busy}, 32'd1);
    drainCheck("t4_drainOld");
    stepClk();
    checkOutput("t4_busyOne", {31'b0, rs1Busy}, 32'd1);
    drainCheck("t4_drainNew");
    stepClk();
    idle(1'b0);
    checkOutput("t4_busyNone", {31'b0, rs1Busy}, 32'd0);

    $display("[TB] simultaneous push and pop");
    applyStimulus(1'b1, 5'd13, 32'h1313, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    expectPush(5'd13, 32'h1313);
    stepClk();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h1414, 1'b1, 1'b0);
    checkOutput("t5_lsuRdy", {31'b0, lsuWbReady}, 32'd1);
    drainCheck("t5_drainPush");
    expectPush(5'd14, 32'h1414);
    stepClk();
    idle(1'b0);
    checkOutput("t5_count", {29'b0, count}, 32'd1);
    idle(1'b1);
    drainCheck("t5_drainLast");
    stepClk();

    $display("[TB] rd zero is consumed");
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    checkOutput("t6_aluRdy", {31'b0, aluWbReady}, 32'd1);
    stepClk();
    checkOutput("t6_count", {29'b0, count}, 32'd0);
    checkOutput("t6_we", {31'b0, rfWriteEnable}, 32'd0);
    checkOutput("t6_rdAddr", {27'b0, rfRdAddress}, 32'd0);
    checkOutput("t6_wrData", rfWriteData, 32'd0);

    $display("[TB] flush with entries queued");
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 5'(i), 32'hF0 + 32'(i), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      stepClk();
    end
    idle(1'b0);
    checkOutput("t7_count", {29'b0, count}, 32'd3);
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    checkOutput("t7_weFlush", {31'b0, rfWriteEnable}, 32'd0);
    checkOutput("t7_aluRdyFlush", {31'b0, aluWbReady}, 32'd0);
    stepClk();
    idle(1'b1);
    checkOutput("t7_countAfter", {29'b0, count}, 32'd0);
    checkOutput("t7_weAfter", {31'b0, rfWriteEnable}, 32'd0);

    $display("[TB] async reset mid-drain");
    queryRs1 = 5'd20;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 5'(20 + i), 32'hB0 + 32'(i), 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      expectPush(5'(20 + i), 32'hB0 + 32'(i));
      stepClk();
    end
    idle(1'b1);
    drainCheck("t8_drainBefore");
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t8_we", {31'b0, rfWriteEnable}, 32'd0);
    checkOutput("t8_count", {29'b0, count}, 32'd0);
    checkOutput("t8_empty", {31'b0, empty}, 32'd1);
    checkOutput("t8_busy", {31'b0, rs1Busy}, 32'd0);
    checkOutput("t8_lsuRdy", {31'b0, lsuWbReady}, 32'd0);
    sbQueue.delete();
    stepClk();
    reset = 1'b1;
    #1;
    checkOutput("t8_weReleased", {31'b0, rfWriteEnable}, 32'd0);
    stepClk();
    checkOutput("t8_stillEmpty", {31'b0, empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
    $finish;
  end

endmodule
